// File: rtl/div_serial_sgn_pkg.sv
// Shared definitions for the serial signed/unsigned divider:
// FSM state type, counter sizing and the conditional two's-complement helper.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Counter width for the default 32-bit build; parameterised users call cnt_width().
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = $clog2(DEF_DATA_W) + 1;

    // Widest datapath the negate helper supports; callers zero-extend and truncate.
    localparam int MAX_W = 128;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    // Two's-complement negate when en is set. Low bits of the result are exact
    // for any narrower operand zero-extended into MAX_W.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

endpackage

// File: rtl/div_serial_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module div_serial_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] dsr_mag,
    output logic [DATA_W-1:0] rem_nxt,
    output logic              q_bit
);

    // One extra bit so the shifted remainder never loses its top bit.
    logic [DATA_W:0] tmp;

    // Trial subtraction; equality must produce a quotient bit of 1.
    always_comb begin
        tmp   = {rem, dvd_bit};
        q_bit = (tmp >= {1'b0, dsr_mag});
        // After a successful subtract the result is below dsr_mag, so the
        // modular low-bit difference is the exact remainder.
        if (q_bit) begin
            rem_nxt = tmp[DATA_W-1:0] - dsr_mag;
        end else begin
            rem_nxt = tmp[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/div_serial_sgn.sv
// Multi-cycle restoring divider, one quotient bit per clock, with per-operation
// signed/unsigned mode and valid/ready handshakes on both sides.
// Optional build macro DIV_SERIAL_SGN_FAST_SPECIAL_EN: divide-by-zero and
// signed-overflow operations bypass the iteration phase.
module div_serial_sgn
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    localparam int                CW      = cnt_width(DATA_W);
    localparam logic [CW-1:0]     LAST    = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_t        state;
    div_state_t        state_nxt;

    // Operands captured at accept; inputs are free to change afterwards.
    logic              sgn_r;
    logic [DATA_W-1:0] dvd_r;
    logic [DATA_W-1:0] dsr_r;

    // Iteration state.
    logic [DATA_W-1:0] dvd_sh;
    logic [DATA_W-1:0] dsr_mag;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [CW-1:0]     cnt;
    logic              neg_q;
    logic              neg_r;
    logic              is_zero;
    logic              is_ovf;

    logic              spec_zero;
    logic              spec_ovf;
    logic [DATA_W-1:0] step_rem;
    logic              step_qbit;

    assign spec_zero = (dsr_r == '0);
    assign spec_ovf  = sgn_r & (dvd_r == MIN_NEG) & (dsr_r == '1);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_serial_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .rem    (rem_q),
        .dvd_bit(dvd_sh[DATA_W-1]),
        .dsr_mag(dsr_mag),
        .rem_nxt(step_rem),
        .q_bit  (step_qbit)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing through accept, prepare, iterate, fix-up, deliver.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = PREP;
                end
            end
            PREP: begin
`ifdef DIV_SERIAL_SGN_FAST_SPECIAL_EN
                if (spec_zero || spec_ovf) begin
                    state_nxt = FIX;
                end else begin
                    state_nxt = CALC;
                end
`else
                state_nxt = CALC;
`endif
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, magnitude/sign prep, MSB-first iteration, result fix-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_r     <= 1'b0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            dvd_sh    <= '0;
            dsr_mag   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_zero   <= 1'b0;
            is_ovf    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn_r <= sign;
                        dvd_r <= dividend;
                        dsr_r <= divisor;
                    end
                end
                PREP: begin
                    dvd_sh  <= DATA_W'(cond_neg(MAX_W'(dvd_r), sgn_r & dvd_r[DATA_W-1]));
                    dsr_mag <= DATA_W'(cond_neg(MAX_W'(dsr_r), sgn_r & dsr_r[DATA_W-1]));
                    neg_q   <= sgn_r & (dvd_r[DATA_W-1] ^ dsr_r[DATA_W-1]);
                    neg_r   <= sgn_r & dvd_r[DATA_W-1];
                    rem_q   <= '0;
                    quo_q   <= '0;
                    cnt     <= '0;
                    is_zero <= spec_zero;
                    is_ovf  <= spec_ovf;
                end
                CALC: begin
                    // The dividend magnitude is shifted out MSB first instead of
                    // indexed by the counter; bit order is the same.
                    rem_q  <= step_rem;
                    quo_q  <= {quo_q[DATA_W-2:0], step_qbit};
                    dvd_sh <= {dvd_sh[DATA_W-2:0], 1'b0};
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    if (is_zero) begin
                        quotient  <= '1;
                        remainder <= dvd_r;
                        div_zero  <= 1'b1;
                    end else if (is_ovf) begin
                        quotient  <= dvd_r;
                        remainder <= '0;
                        div_zero  <= 1'b0;
                    end else begin
                        quotient  <= DATA_W'(cond_neg(MAX_W'(quo_q), neg_q));
                        remainder <= DATA_W'(cond_neg(MAX_W'(rem_q), neg_r));
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_serial_sgn.sv
// Scoreboard bench for div_serial_sgn: a driver pushes expected results from a
// plain-arithmetic reference model, a monitor pops and checks on out_valid.
module tb_div_serial_sgn;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    div_serial_sgn #(
        .DATA_W(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        longint       lat;
        longint       acc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     hold_req = 0;
    exp_t   cur;
    logic   active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Reference: plain division on wide signed/unsigned integers.
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sd;
        logic   special;
        e.dz = 1'b0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sd  = longint'($signed(b));
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
        end
        special = (b == '0) || (s && a == 32'h8000_0000 && b == '1);
`ifdef DIV_SERIAL_SGN_FAST_SPECIAL_EN
        e.lat = special ? 2 : W + 2;
`else
        e.lat = (special || !special) ? W + 2 : W + 2;
`endif
        e.acc = 0;
        return e;
    endfunction

    // Called at a negedge; holds in_valid (ignored while busy) until accepted.
    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int unsigned n = 0;
        sign     = s;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                timeout_fail("accept_wait");
                in_valid = 1'b0;
                return;
            end
        end
        e     = model(s, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        sign     = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: pop on the first valid cycle, then require stable outputs until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (out_valid) begin
                if (!active) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result got q=%h r=%h expected none", quotient, remainder);
                    end else begin
                        cur    = sb.pop_front();
                        active = 1'b1;
                        check("quotient", 64'(quotient), 64'(cur.q));
                        check("remainder", 64'(remainder), 64'(cur.r));
                        check("div_zero", 64'(div_zero), 64'(cur.dz));
                        check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                    end
                end else begin
                    check("hold_quotient", 64'(quotient), 64'(cur.q));
                    check("hold_remainder", 64'(remainder), 64'(cur.r));
                    check("hold_div_zero", 64'(div_zero), 64'(cur.dz));
                end
                if (hold_req > 0) begin
                    out_ready = 1'b0;
                    hold_req--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                active    = 1'b0;
                out_ready = (hold_req > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail(name);
    endtask

    initial begin
        int unsigned kind;
        logic        s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases; first result is held off for 10 cycles.
        hold_req = 10;
        do_op(1'b0, 32'd100, 32'd7);
        do_op(1'b0, 32'd7, 32'd7);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op(1'b0, 32'd7, 32'd0);
        do_op(1'b1, 32'd7, 32'd0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b1, 32'h8000_0000, 32'd0);
        drain("drain_directed");

        // Reset while iterating: nothing is emitted and the block returns to idle.
        do_op(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_op(1'b0, 32'd100, 32'd7);
        drain("drain_abort");

        // Randomised back-to-back operations.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            s    = 1'($urandom);
            a    = $urandom;
            b    = $urandom;
            if (kind == 0) begin
                b = '0;
            end else if (kind == 1) begin
                s = 1'b1;
                a = 32'h8000_0000;
                b = '1;
            end else if (kind == 2) begin
                b = W'($urandom_range(1, 20));
            end else if (kind == 3) begin
                b = W'(-$signed(W'($urandom_range(1, 20))));
            end
            do_op(s, a, b);
        end
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
